fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the main decoder.
- Holds the PC and requests instruction words from a variable-latency instruction memory using a req/ack handshake.
- Presents each fetched word to decode, where bits [31:21] form the decoder opcode, and holds it until decode/execute accepts it.
- On acceptance, advances the PC to PC+4 or to the branch target.

Parameters:
N, 64, PC and address width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  N  fetch byte address; equals current pc
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
instr  out  32  captured instruction for decode
instr_pc  out  N  address of instr
instr_valid  out  1  instr/instr_pc hold a word not yet consumed
dec_ready  in  1  decode/execute consumes instr this cycle
PCSrc  in  1  taken branch; sampled only in the consume cycle
branch_target  in  N  next PC when PCSrc=1
halted  out  1  fetch stopped by HLT (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, halted=0.
- Reset dominates every other input in the same cycle.
- States: IDLE, REQ, HOLD, HALT. HALT exists only with the macro.
- IDLE:
  - imem_req=0.
  - Unconditionally go to REQ next cycle.
- REQ:
  - imem_req=1 and imem_addr=pc; both held stable until ack.
  - On imem_ack=1, same edge: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - Ack latency is unbounded; wait indefinitely.
  - Ack in the same cycle as req is legal (0-wait memory).
- HOLD:
  - imem_req=0; instr/instr_pc/instr_valid held stable.
  - If dec_ready=1 (consume): instr_valid<=0, pc<=PCSrc ? {branch_target[N-1:2],2'b00} : pc+4, go to REQ.
  - If dec_ready=0: remain in HOLD; PCSrc and branch_target ignored.
- imem_ack outside REQ is ignored (no capture, no state change).
- dec_ready outside HOLD is ignored.
- PC arithmetic: pc+4 wraps modulo 2^N, e.g. 2^N-4 -> 0.
- Branch target bits [1:0] are always forced to 0.
- Throughput: one instruction per 2 cycles with a 0-wait memory and dec_ready held at 1 (REQ, HOLD, REQ, ...).
- Reset mid-operation:
  - In REQ, the pending request is abandoned; a late ack after reset is ignored because the state is IDLE.
  - In HOLD, the held word is discarded (instr_valid=0).

Optional Feature:
- Macro: FETCH_HALT_EN
- With macro:
  - When a word captured in REQ equals 32'hD440_0000 (HLT #0), it is not presented: instr_valid stays 0 and the state goes to HALT.
  - In HALT: halted=1, imem_req=0; pc stays at the HLT address and all inputs are ignored until reset.
- Without macro:
  - HALT state absent; halted tied to 0.
  - 32'hD440_0000 is fetched and presented like any other word.

Test Plan:
1. Reset, then 0-wait memory returning 32'hF840_0000 at addr 0, dec_ready=1, PCSrc=0 -> imem_req rises the cycle after IDLE; instr=F8400000, instr_pc=0, instr_valid=1 for one cycle; next imem_addr=4.
2. Ack delayed 3 cycles -> imem_req=1 and imem_addr held for 4 cycles; exactly one capture; instr_valid stays 0 until the ack edge.
3. Backpressure: dec_ready=0 for 5 cycles in HOLD, PCSrc toggling -> instr stable, no new req, pc unchanged; dec_ready=1 with PCSrc=1, branch_target=0x103 -> next imem_addr=0x100.
4. Wrap: RESET_PC=2^64-4, consume with PCSrc=0 -> next imem_addr=0.
5. Assert reset during REQ, then imem_ack=1 the cycle after -> no capture, instr_valid=0, pc=RESET_PC, req resumes after IDLE.
6. FETCH_HALT_EN: word 32'hD440_0000 at addr 8 -> instr_valid never asserts for it, halted=1, imem_req=0 thereafter; reset clears halted. Without the macro, the same word is presented with instr_valid=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words over a req/ack memory
// handshake and holds each word for decode. The HLT stop is enabled by FETCH_HALT_EN.
module fetch_unit #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         dec_ready,
    input  logic         PCSrc,
    input  logic [N-1:0] branch_target,
    output logic         halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
`ifdef FETCH_HALT_EN
        ,
        HALT = 2'd3
`endif
    } state_t;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] HLT_WORD = 32'hD440_0000;
`endif

    state_t         state_reg, state_next;
    logic [N-1:0]   pc_reg, pc_next;
    logic [31:0]    instr_reg, instr_next;
    logic [N-1:0]   instr_pc_reg, instr_pc_next;
    logic           valid_reg, valid_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack) begin
`ifdef FETCH_HALT_EN
                    // A HLT word is swallowed here and never reaches decode.
                    if (imem_rdata == HLT_WORD) begin
                        state_next = HALT;
                    end else begin
`else
                    begin
`endif
                        instr_next    = imem_rdata;
                        instr_pc_next = pc_reg;
                        valid_next    = 1'b1;
                        state_next    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (dec_ready) begin
                    valid_next = 1'b0;
                    pc_next    = PCSrc ? {branch_target[N-1:2], 2'b00} : pc_reg + N'(4);
                    state_next = REQ;
                end
            end
`ifdef FETCH_HALT_EN
            HALT: state_next = HALT;
`endif
            default: state_next = IDLE;
        endcase
    end

    assign imem_req    = (state_reg == REQ);
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = valid_reg;
`ifdef FETCH_HALT_EN
    assign halted      = (state_reg == HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level model of the
// fetch loop, plus a short directed PC-wrap run on a second instance.
module tb_fetch_unit;

    localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] HLT_WORD = 32'hD440_0000;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_ack, dec_ready, PCSrc;
    logic [31:0] imem_rdata;
    logic [63:0] branch_target;
    logic        imem_req, instr_valid, halted;
    logic [63:0] imem_addr, instr_pc;
    logic [31:0] instr;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .dec_ready(dec_ready), .PCSrc(PCSrc), .branch_target(branch_target),
        .halted(halted)
    );

    logic        w_reset, w_ack, w_dec_ready, w_pcsrc;
    logic [31:0] w_rdata;
    logic [63:0] w_bt;
    logic        w_req, w_valid, w_halted;
    logic [63:0] w_addr, w_instr_pc;
    logic [31:0] w_instr;

    fetch_unit #(.N(64), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset(w_reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_valid),
        .dec_ready(w_dec_ready), .PCSrc(w_pcsrc), .branch_target(w_bt),
        .halted(w_halted)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: after reset one idle cycle, then the fetch loop alternates
    // "waiting for memory" and "word held for decode"; halt freezes it.
    logic [63:0] m_pc, m_instr_pc;
    logic [31:0] m_instr;
    bit          m_valid, m_fresh, m_halted, m_after_reset;

    task automatic model_step();
        m_after_reset = 1'b0;
        if (reset) begin
            m_pc = 64'd0; m_instr = '0; m_instr_pc = '0;
            m_valid = 1'b0; m_fresh = 1'b1; m_halted = 1'b0; m_after_reset = 1'b1;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (m_valid) begin
            if (dec_ready) begin
                $display("consume pc=%h instr=%h branch=%0d", m_instr_pc, m_instr, PCSrc);
                m_valid = 1'b0;
                m_pc = PCSrc ? (branch_target & ~64'd3) : m_pc + 64'd4;
            end
        end else if (imem_ack) begin
            if (HALT_EN && imem_rdata == HLT_WORD) begin
                m_halted = 1'b1;
                $display("halt at pc=%h", m_pc);
            end else begin
                m_valid = 1'b1; m_instr = imem_rdata; m_instr_pc = m_pc;
            end
        end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; dec_ready = 1'b0; PCSrc = 1'b0;
        imem_rdata = '0; branch_target = '0;
        w_reset = 1'b1; w_ack = 1'b0; w_dec_ready = 1'b0; w_pcsrc = 1'b0;
        w_rdata = 32'h1234_5678; w_bt = '0;
        @(posedge clk);
        model_step();

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            check("req", imem_req, !m_fresh && !m_valid && !m_halted);
            check("addr", imem_addr, m_pc);
            check("valid", instr_valid, m_valid);
            check("halted", halted, m_halted);
            if (m_valid || m_after_reset) begin
                check("instr", instr, m_instr);
                check("instr_pc", instr_pc, m_instr_pc);
            end
            reset     = (i < 2) || ($urandom_range(0, 59) == 0);
            imem_ack  = $urandom_range(0, 2) == 0;
            dec_ready = $urandom_range(0, 2) != 0;
            PCSrc     = $urandom_range(0, 3) == 0;
            case ($urandom_range(0, 9))
                0:       imem_rdata = HLT_WORD;
                1:       imem_rdata = 32'hF840_0000;
                default: imem_rdata = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0)
                branch_target = WRAP_PC | 64'($urandom_range(0, 3));
            else
                branch_target = {$urandom, $urandom};
            @(posedge clk);
            model_step();
        end

        // Wrap: start at 2^64-4, 0-wait memory, consume straight away.
        w_ack = 1'b1; w_dec_ready = 1'b1;
        @(negedge clk);
        check("wrap_idle_req", w_req, 1'b0);
        check("wrap_idle_addr", w_addr, WRAP_PC);
        w_reset = 1'b0;
        @(negedge clk);
        check("wrap_req", w_req, 1'b1);
        @(negedge clk);
        check("wrap_valid", w_valid, 1'b1);
        check("wrap_instr", w_instr, 32'h1234_5678);
        check("wrap_instr_pc", w_instr_pc, WRAP_PC);
        @(negedge clk);
        check("wrap_next_addr", w_addr, 64'd0);
        check("wrap_next_req", w_req, 1'b1);
        $display("wrap consume pc=%h next=%h", WRAP_PC, w_addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
